zoom_ctrl: RTL

Sequencer for the `zoomer` coordinate-scaling datapath in the SuperGA pipeline. On each `start`, it rasterises one output window: it emits every (x, y) pair in row-major order on a valid/ready stream into `zoomer`, with the zoom factor held constant for the whole frame. At each frame start, the zoom factor ramps one step toward a software-written target, which gives smooth zoom animation without display tearing.

---
 rtl/zoom_ctrl_pkg.sv | 18 +
 rtl/zoom_ctrl_if.sv | 25 ++
 rtl/zoom_ctrl_ramp.sv | 36 +++
 rtl/zoom_ctrl.sv | 123 ++++++++++++
 4 files changed

// File: rtl/zoom_ctrl_pkg.sv
`default_nettype none
// ------------------------------------------------------------------
// zoom_ctrl_pkg : shared widths and FSM encoding for zoom_ctrl
// Rev 1.0
// ------------------------------------------------------------------
package zoom_ctrl_pkg;

  localparam int COORD_W = 8;
  localparam int ZOOM_W  = 8;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    SCAN      = 2'd1,
    FRAME_END = 2'd2
  } state_e;

endpackage
`default_nettype wire

// File: rtl/zoom_ctrl_if.sv
`default_nettype none
// ------------------------------------------------------------------
// zoom_ctrl_if : coordinate valid/ready stream into zoomer
// Rev 1.0
// ------------------------------------------------------------------
interface zoom_ctrl_if;
  import zoom_ctrl_pkg::*;

  logic               coord_valid;
  logic               coord_ready;
  logic [COORD_W-1:0] Xcoord;
  logic [COORD_W-1:0] Ycoord;
  logic [ZOOM_W-1:0]  Zoom;

  modport master (
    output coord_valid, Xcoord, Ycoord, Zoom,
    input  coord_ready
  );

  modport slave (
    input  coord_valid, Xcoord, Ycoord, Zoom,
    output coord_ready
  );
endinterface
`default_nettype wire

// File: rtl/zoom_ctrl_ramp.sv
`default_nettype none
// ------------------------------------------------------------------
// zoom_ramp : one clamped step of current value toward a target
// Rev 1.0
// ------------------------------------------------------------------
module zoom_ramp
  import zoom_ctrl_pkg::*;
(
  input  wire logic [ZOOM_W-1:0] cur_i,
  input  wire logic [ZOOM_W-1:0] target_i,
  input  wire logic [ZOOM_W-1:0] step_i,
  output logic      [ZOOM_W-1:0] next_o
);

  logic [ZOOM_W:0] w_up;
  logic [ZOOM_W:0] w_dn;
  logic [ZOOM_W:0] w_tgt;

  // Extra bit catches both carry-out and borrow so the result clamps instead of wrapping
  assign w_up  = {1'b0, cur_i} + {1'b0, step_i};
  assign w_dn  = {1'b0, cur_i} - {1'b0, step_i};
  assign w_tgt = {1'b0, target_i};

  always_comb begin
    next_o = cur_i;
    if (target_i > cur_i) begin
      if (w_up > w_tgt) next_o = target_i;
      else              next_o = w_up[ZOOM_W-1:0];
    end else if (target_i < cur_i) begin
      if (w_dn[ZOOM_W] || (w_dn < w_tgt)) next_o = target_i;
      else                                next_o = w_dn[ZOOM_W-1:0];
    end
  end

endmodule
`default_nettype wire

// File: rtl/zoom_ctrl.sv
`default_nettype none
// ------------------------------------------------------------------
// zoom_ctrl : row-major window raster with per-frame zoom ramp
// Rev 1.0
// ------------------------------------------------------------------
module zoom_ctrl
  import zoom_ctrl_pkg::*;
#(
  parameter int XMAX       = 159,
  parameter int YMAX       = 119,
  parameter int ZOOM_STEP  = 1,
  parameter int ZOOM_RESET = 1
) (
  input  wire logic              ACLK,
  input  wire logic              ARESETN,
  input  wire logic              start,
  input  wire logic [ZOOM_W-1:0] zoom_target,
  input  wire logic              zoom_target_we,
  output logic                   busy,
  output logic                   frame_done,
  zoom_ctrl_if.master            coord
);

  localparam logic [COORD_W-1:0] c_XMAX       = COORD_W'(XMAX);
  localparam logic [COORD_W-1:0] c_YMAX       = COORD_W'(YMAX);
  localparam logic [ZOOM_W-1:0]  c_ZOOM_STEP  = ZOOM_W'(ZOOM_STEP);
  localparam logic [ZOOM_W-1:0]  c_ZOOM_RESET = ZOOM_W'(ZOOM_RESET);

  state_e             state_q, state_d;
  logic [COORD_W-1:0] x_q, x_d;
  logic [COORD_W-1:0] y_q, y_d;
  logic [ZOOM_W-1:0]  zoom_q, zoom_d;
  logic [ZOOM_W-1:0]  target_q, target_d;
  logic               valid_q, valid_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [ZOOM_W-1:0]  w_zoom_next;

  zoom_ramp u_ramp (
    .cur_i    (zoom_q),
    .target_i (target_q),
    .step_i   (c_ZOOM_STEP),
    .next_o   (w_zoom_next)
  );

  always_comb begin
    state_d  = state_q;
    x_d      = x_q;
    y_d      = y_q;
    zoom_d   = zoom_q;
    valid_d  = 1'b0;
    busy_d   = 1'b0;
    done_d   = 1'b0;
    // Ramp reads target_q, so a write in the same cycle as start lands next frame
    target_d = zoom_target_we ? zoom_target : target_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = SCAN;
          x_d     = '0;
          y_d     = '0;
          zoom_d  = w_zoom_next;
          valid_d = 1'b1;
          busy_d  = 1'b1;
        end
      end
      SCAN: begin
        valid_d = 1'b1;
        busy_d  = 1'b1;
        if (coord.coord_ready) begin
          if (x_q < c_XMAX) begin
            x_d = x_q + 8'd1;
          end else if (y_q < c_YMAX) begin
            x_d = '0;
            y_d = y_q + 8'd1;
          end else begin
            state_d = FRAME_END;
            valid_d = 1'b0;
            done_d  = 1'b1;
          end
        end
      end
      FRAME_END: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      state_q  <= IDLE;
      x_q      <= '0;
      y_q      <= '0;
      zoom_q   <= c_ZOOM_RESET;
      target_q <= c_ZOOM_RESET;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      x_q      <= x_d;
      y_q      <= y_d;
      zoom_q   <= zoom_d;
      target_q <= target_d;
      valid_q  <= valid_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign coord.coord_valid = valid_q;
  assign coord.Xcoord      = x_q;
  assign coord.Ycoord      = y_q;
  assign coord.Zoom        = zoom_q;
  assign busy              = busy_q;
  assign frame_done        = done_q;

endmodule
`default_nettype wire
